qr_sweep_ctrl: RTL and testbench

QR_SWEEP_CTRL -- requirements
Module: qr_sweep_ctrl

---
 rtl/qr_pkg.sv | 22 ++
 rtl/qr_mat_store.sv | 78 +++++++
 rtl/qr_sweep_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_qr_sweep_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qr_pkg.sv
// Shared definitions for the QR sweep controller: FSM states, PE mode
// encodings, default sample width and an index-width helper.
package qr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        COMP = 2'd2,
        SEND = 2'd3
    } qr_state_e;

    localparam logic PE_VEC = 1'b1;
    localparam logic PE_ROT = 1'b0;

    localparam int DEF_BIT_NUM = 18;

    // Width of an index into n entries, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/qr_mat_store.sv
// ROWS x COLS complex register file. Ports: a row-pair read (rows r, r+1 at
// one column), a row-pair write, a single-element write used for ingest and a
// single-element read used for egress. All reads are combinational.
module qr_mat_store
    import qr_pkg::*;
#(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int BIT_NUM = DEF_BIT_NUM,
    parameter int RW      = idx_w(ROWS),
    parameter int CW      = idx_w(COLS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [RW-1:0]             rp_row_i,
    input  logic [CW-1:0]             rp_col_i,
    output logic signed [BIT_NUM-1:0] rp_x0_o,
    output logic signed [BIT_NUM-1:0] rp_y0_o,
    output logic signed [BIT_NUM-1:0] rp_x1_o,
    output logic signed [BIT_NUM-1:0] rp_y1_o,
    input  logic                      wp_en_i,
    input  logic [RW-1:0]             wp_row_i,
    input  logic [CW-1:0]             wp_col_i,
    input  logic signed [BIT_NUM-1:0] wp_x0_i,
    input  logic signed [BIT_NUM-1:0] wp_y0_i,
    input  logic signed [BIT_NUM-1:0] wp_x1_i,
    input  logic signed [BIT_NUM-1:0] wp_y1_i,
    input  logic                      ew_en_i,
    input  logic [RW-1:0]             ew_row_i,
    input  logic [CW-1:0]             ew_col_i,
    input  logic signed [BIT_NUM-1:0] ew_re_i,
    input  logic signed [BIT_NUM-1:0] ew_im_i,
    input  logic [RW-1:0]             sr_row_i,
    input  logic [CW-1:0]             sr_col_i,
    output logic signed [BIT_NUM-1:0] sr_re_o,
    output logic signed [BIT_NUM-1:0] sr_im_o
);

    logic signed [BIT_NUM-1:0] re_q [ROWS][COLS];
    logic signed [BIT_NUM-1:0] im_q [ROWS][COLS];

    // The lower row of a pair is always odd, so r+1 fits in RW bits.
    logic [RW-1:0] rp_row_lo;
    logic [RW-1:0] wp_row_lo;
    assign rp_row_lo = rp_row_i + RW'(1);
    assign wp_row_lo = wp_row_i + RW'(1);

    assign rp_x0_o = re_q[rp_row_i][rp_col_i];
    assign rp_y0_o = im_q[rp_row_i][rp_col_i];
    assign rp_x1_o = re_q[rp_row_lo][rp_col_i];
    assign rp_y1_o = im_q[rp_row_lo][rp_col_i];
    assign sr_re_o = re_q[sr_row_i][sr_col_i];
    assign sr_im_o = im_q[sr_row_i][sr_col_i];

    // Storage: cleared on reset, written by ingest or PE write-back (never both at once).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    re_q[r][c] <= '0;
                    im_q[r][c] <= '0;
                end
            end
        end else begin
            if (ew_en_i) begin
                re_q[ew_row_i][ew_col_i] <= ew_re_i;
                im_q[ew_row_i][ew_col_i] <= ew_im_i;
            end
            if (wp_en_i) begin
                re_q[wp_row_i][wp_col_i]  <= wp_x0_i;
                im_q[wp_row_i][wp_col_i]  <= wp_y0_i;
                re_q[wp_row_lo][wp_col_i] <= wp_x1_i;
                im_q[wp_row_lo][wp_col_i] <= wp_y1_i;
            end
        end
    end

endmodule

// File: rtl/qr_sweep_ctrl.sv
// QR sweep controller: ingests a ROWS x COLS complex matrix, issues one PE
// job per cycle for every (row pair, column), writes PE results back in issue
// order, then streams the matrix out. Define QR_SWEEP_COLMAJOR_OUT_EN for
// column-major output order; otherwise output is row-major like the input.
module qr_sweep_ctrl
    import qr_pkg::*;
#(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int BIT_NUM = DEF_BIT_NUM
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [BIT_NUM-1:0] in_re,
    input  logic signed [BIT_NUM-1:0] in_im,
    output logic                      pe_valid,
    output logic                      pe_vec,
    output logic signed [BIT_NUM-1:0] pe_x0,
    output logic signed [BIT_NUM-1:0] pe_y0,
    output logic signed [BIT_NUM-1:0] pe_x1,
    output logic signed [BIT_NUM-1:0] pe_y1,
    input  logic                      pe_rvalid,
    input  logic signed [BIT_NUM-1:0] pe_rx0,
    input  logic signed [BIT_NUM-1:0] pe_ry0,
    input  logic signed [BIT_NUM-1:0] pe_rx1,
    input  logic signed [BIT_NUM-1:0] pe_ry1,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [BIT_NUM-1:0] out_re,
    output logic signed [BIT_NUM-1:0] out_im,
    output logic                      busy,
    output logic                      err
);

    localparam int J  = (ROWS / 2) * COLS;
    localparam int RW = idx_w(ROWS);
    localparam int CW = idx_w(COLS);
    localparam int JW = $clog2(J + 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    localparam logic [RW-1:0] PAIR_LAST = RW'(ROWS - 2);
    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
    localparam logic [JW-1:0] J_CNT     = JW'(J);
    localparam logic [JW-1:0] J_LAST    = JW'(J - 1);

    qr_state_e     state_q, state_d;
    logic [RW-1:0] er_q, er_d;      // ingest / egress element position
    logic [CW-1:0] ec_q, ec_d;
    logic [RW-1:0] ir_q, ir_d;      // next job to issue (upper row, column)
    logic [CW-1:0] ic_q, ic_d;
    logic [JW-1:0] icnt_q, icnt_d;
    logic [RW-1:0] wr_q, wr_d;      // oldest outstanding job (write-back target)
    logic [CW-1:0] wc_q, wc_d;
    logic [JW-1:0] wcnt_q, wcnt_d;
    logic          err_q, err_d;

    logic in_xfer, out_xfer, issue, wb_ok, wb_acc, last_elem;
    logic signed [BIT_NUM-1:0] rd_x0, rd_y0, rd_x1, rd_y1, sr_re, sr_im;

    assign in_ready  = (state_q == IDLE) || (state_q == RECV);
    assign in_xfer   = in_valid && in_ready;
    assign out_valid = (state_q == SEND);
    assign out_xfer  = out_valid && out_ready;
    assign issue     = (state_q == COMP) && (icnt_q != J_CNT);
    assign wb_ok     = (state_q == COMP) && (wcnt_q != icnt_q);
    assign wb_acc    = pe_rvalid && wb_ok;
    assign last_elem = (er_q == ROW_LAST) && (ec_q == COL_LAST);
    assign busy      = (state_q != IDLE);
    assign err       = err_q;

    assign pe_valid = issue;
    assign pe_vec   = (issue && ic_q == '0) ? PE_VEC : PE_ROT;
    assign pe_x0    = issue ? rd_x0 : '0;
    assign pe_y0    = issue ? rd_y0 : '0;
    assign pe_x1    = issue ? rd_x1 : '0;
    assign pe_y1    = issue ? rd_y1 : '0;
    assign out_re   = out_valid ? sr_re : '0;
    assign out_im   = out_valid ? sr_im : '0;

    qr_mat_store #(
        .ROWS(ROWS), .COLS(COLS), .BIT_NUM(BIT_NUM), .RW(RW), .CW(CW)
    ) u_store (
        .clk(clk), .rst_n(rst_n),
        .rp_row_i(ir_q), .rp_col_i(ic_q),
        .rp_x0_o(rd_x0), .rp_y0_o(rd_y0), .rp_x1_o(rd_x1), .rp_y1_o(rd_y1),
        .wp_en_i(wb_acc), .wp_row_i(wr_q), .wp_col_i(wc_q),
        .wp_x0_i(pe_rx0), .wp_y0_i(pe_ry0), .wp_x1_i(pe_rx1), .wp_y1_i(pe_ry1),
        .ew_en_i(in_xfer), .ew_row_i(er_q), .ew_col_i(ec_q),
        .ew_re_i(in_re), .ew_im_i(in_im),
        .sr_row_i(er_q), .sr_col_i(ec_q),
        .sr_re_o(sr_re), .sr_im_o(sr_im)
    );

    // State and counter registers; reset may arrive at any point of a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            er_q    <= '0;
            ec_q    <= '0;
            ir_q    <= '0;
            ic_q    <= '0;
            icnt_q  <= '0;
            wr_q    <= '0;
            wc_q    <= '0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            er_q    <= er_d;
            ec_q    <= ec_d;
            ir_q    <= ir_d;
            ic_q    <= ic_d;
            icnt_q  <= icnt_d;
            wr_q    <= wr_d;
            wc_q    <= wc_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
        end
    end

    // Next state: ingest walk, job issue, in-order write-back and egress walk.
    always_comb begin
        state_d = state_q;
        er_d    = er_q;
        ec_d    = ec_q;
        ir_d    = ir_q;
        ic_d    = ic_q;
        icnt_d  = icnt_q;
        wr_d    = wr_q;
        wc_d    = wc_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;

        // A result with nothing outstanding (or outside COMP) is dropped and flagged.
        if (pe_rvalid && !wb_ok) err_d = 1'b1;

        if (issue) begin
            icnt_d = icnt_q + JW'(1);
            if (ic_q == COL_LAST) begin
                ic_d = '0;
                ir_d = (ir_q == PAIR_LAST) ? '0 : ir_q + RW'(2);
            end else begin
                ic_d = ic_q + CW'(1);
            end
        end

        if (wb_acc) begin
            wcnt_d = wcnt_q + JW'(1);
            if (wc_q == COL_LAST) begin
                wc_d = '0;
                wr_d = (wr_q == PAIR_LAST) ? '0 : wr_q + RW'(2);
            end else begin
                wc_d = wc_q + CW'(1);
            end
        end

        case (state_q)
            IDLE, RECV: begin
                if (in_xfer) begin
                    if (last_elem) begin
                        state_d = COMP;
                        er_d    = '0;
                        ec_d    = '0;
                    end else begin
                        state_d = RECV;
                        if (ec_q == COL_LAST) begin
                            ec_d = '0;
                            er_d = er_q + RW'(1);
                        end else begin
                            ec_d = ec_q + CW'(1);
                        end
                    end
                end
            end
            COMP: begin
                if (wb_acc && wcnt_q == J_LAST) begin
                    state_d = SEND;
                    icnt_d  = '0;
                    wcnt_d  = '0;
                end
            end
            SEND: begin
                if (out_xfer) begin
                    if (last_elem) begin
                        state_d = IDLE;
                        er_d    = '0;
                        ec_d    = '0;
                    end else begin
`ifdef QR_SWEEP_COLMAJOR_OUT_EN
                        if (er_q == ROW_LAST) begin
                            er_d = '0;
                            ec_d = ec_q + CW'(1);
                        end else begin
                            er_d = er_q + RW'(1);
                        end
`else
                        if (ec_q == COL_LAST) begin
                            ec_d = '0;
                            er_d = er_q + RW'(1);
                        end else begin
                            ec_d = ec_q + CW'(1);
                        end
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_qr_sweep_ctrl.sv
// Directed bench for qr_sweep_ctrl: a 4x4 instance driven by an identity PE
// with 3-cycle latency, and a 6x3 instance driven by a 1-cycle identity PE.
// Expected output order follows QR_SWEEP_COLMAJOR_OUT_EN.
module tb_qr_sweep_ctrl;

    localparam int BN = 18;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int nasrt = 0;
    int nfail = 0;

    // 4x4 instance
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [BN-1:0] in_re = '0, in_im = '0;
    logic                 pe_valid, pe_vec;
    logic signed [BN-1:0] pe_x0, pe_y0, pe_x1, pe_y1;
    logic                 pe_rvalid;
    logic signed [BN-1:0] pe_rx0, pe_ry0, pe_rx1, pe_ry1;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [BN-1:0] out_re, out_im;
    logic                 busy, err;

    logic                 tb_rv = 1'b0;
    logic [4*BN-1:0]      tb_data = '0;
    logic [2:0]           mv = '0;
    logic [4*BN-1:0]      md [3] = '{default: '0};

    // Identity PE with 3-cycle latency, deliberately not reset.
    always_ff @(posedge clk) begin
        mv    <= {mv[1:0], pe_valid};
        md[0] <= {pe_x0, pe_y0, pe_x1, pe_y1};
        md[1] <= md[0];
        md[2] <= md[1];
    end
    assign pe_rvalid = mv[2] | tb_rv;
    assign {pe_rx0, pe_ry0, pe_rx1, pe_ry1} = tb_rv ? tb_data : md[2];

    qr_sweep_ctrl #(.ROWS(4), .COLS(4), .BIT_NUM(BN)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
        .pe_valid(pe_valid), .pe_vec(pe_vec),
        .pe_x0(pe_x0), .pe_y0(pe_y0), .pe_x1(pe_x1), .pe_y1(pe_y1),
        .pe_rvalid(pe_rvalid),
        .pe_rx0(pe_rx0), .pe_ry0(pe_ry0), .pe_rx1(pe_rx1), .pe_ry1(pe_ry1),
        .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .busy(busy), .err(err)
    );

    // 6x3 instance
    logic                 in_valid6 = 1'b0;
    logic                 in_ready6;
    logic signed [BN-1:0] in_re6 = '0, in_im6 = '0;
    logic                 pe_valid6, pe_vec6;
    logic signed [BN-1:0] pe_x06, pe_y06, pe_x16, pe_y16;
    logic                 v6 = 1'b0;
    logic [4*BN-1:0]      d6 = '0;
    logic signed [BN-1:0] pe_rx06, pe_ry06, pe_rx16, pe_ry16;
    logic                 out_valid6;
    logic signed [BN-1:0] out_re6, out_im6;
    logic                 busy6, err6;

    // Identity PE with 1-cycle latency for the 6x3 instance.
    always_ff @(posedge clk) begin
        v6 <= pe_valid6;
        d6 <= {pe_x06, pe_y06, pe_x16, pe_y16};
    end
    assign {pe_rx06, pe_ry06, pe_rx16, pe_ry16} = d6;

    qr_sweep_ctrl #(.ROWS(6), .COLS(3), .BIT_NUM(BN)) dut6 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid6), .in_ready(in_ready6), .in_re(in_re6), .in_im(in_im6),
        .pe_valid(pe_valid6), .pe_vec(pe_vec6),
        .pe_x0(pe_x06), .pe_y0(pe_y06), .pe_x1(pe_x16), .pe_y1(pe_y16),
        .pe_rvalid(v6),
        .pe_rx0(pe_rx06), .pe_ry0(pe_ry06), .pe_rx1(pe_rx16), .pe_ry1(pe_ry16),
        .out_valid(out_valid6), .out_ready(1'b1), .out_re(out_re6), .out_im(out_im6),
        .busy(busy6), .err(err6)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nasrt++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Value expected at egress position s of a matrix whose element (r,c) holds r*cols+c.
    function automatic logic signed [BN-1:0] exp_at(input int s, input int rows, input int cols);
`ifdef QR_SWEEP_COLMAJOR_OUT_EN
        return BN'((s % rows) * cols + s / rows);
`else
        if (rows < 0) return '0;
        return BN'(s);
`endif
    endfunction

    // Feed samples k=0..15 (re=k, im=-k), optionally with a bubble between samples.
    task automatic send_frame(input bit gap);
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1;
            in_re    = BN'(k);
            in_im    = -BN'(k);
            @(negedge clk);
            if (gap && k != 15) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        chk("in_ready_in_comp", in_ready, 1'b0);
        chk("busy_in_comp", busy, 1'b1);
    endtask

    // Observe COMP: job count, contiguity, vectoring pattern and operands.
    task automatic watch_comp();
        int jobs  = 0;
        int first = -1;
        int last  = -1;
        logic [15:0] pat = '0;
        logic signed [BN-1:0] e0, e1;
        for (int cyc = 0; cyc < 200 && !out_valid; cyc++) begin
            if (pe_valid) begin
                if (first < 0) first = cyc;
                last = cyc;
                pat  = {pat[14:0], pe_vec};
                e0   = BN'(2 * (jobs / 4) * 4 + jobs % 4);
                e1   = e0 + BN'(4);
                chk("pe_x0", pe_x0, e0);
                chk("pe_y0", pe_y0, -e0);
                chk("pe_x1", pe_x1, e1);
                chk("pe_y1", pe_y1, -e1);
                jobs++;
            end
            @(negedge clk);
        end
        chk("send_reached", out_valid, 1'b1);
        chk("job_count", jobs, 8);
        chk("issue_start", first, 0);
        chk("issue_span", last - first + 1, 8);
        chk("vec_pattern", pat, 16'h0088);
    endtask

    // Drain SEND, optionally holding out_ready low for stall_len cycles at position stall_at.
    task automatic recv_frame(input int stall_at, input int stall_len);
        logic signed [BN-1:0] ev, eim;
        for (int s = 0; s < 16; s++) begin
            ev  = exp_at(s, 4, 4);
            eim = -ev;
            if (s == stall_at) begin
                out_ready = 1'b0;
                for (int h = 0; h < stall_len; h++) begin
                    chk("stall_valid", out_valid, 1'b1);
                    chk("stall_re", out_re, ev);
                    chk("stall_im", out_im, eim);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
            chk("out_valid", out_valid, 1'b1);
            chk("out_re", out_re, ev);
            chk("out_im", out_im, eim);
            @(negedge clk);
        end
        chk("out_valid_after", out_valid, 1'b0);
        chk("busy_after", busy, 1'b0);
        chk("in_ready_after", in_ready, 1'b1);
    endtask

    initial begin
        int jobs;
        logic [15:0] pat;
        logic signed [BN-1:0] ev, eim;

        // Reset values
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_pe_valid", pe_valid, 1'b0);
        chk("rst_pe_vec", pe_vec, 1'b0);
        chk("rst_pe_x0", pe_x0, '0);
        chk("rst_pe_y1", pe_y1, '0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_re", out_re, '0);
        chk("rst_out_im", out_im, '0);
        chk("rst_err", err, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Contiguous frame
        send_frame(1'b0);
        watch_comp();
        recv_frame(-1, 0);

        // in_valid toggling every other cycle
        send_frame(1'b1);
        watch_comp();
        recv_frame(-1, 0);

        // Back-pressure at element 7
        send_frame(1'b0);
        watch_comp();
        recv_frame(7, 5);
        chk("err_clean_frames", err, 1'b0);

        // Stray PE result in IDLE
        tb_data = {BN'(77), BN'(55), BN'(99), BN'(33)};
        tb_rv   = 1'b1;
        @(negedge clk);
        tb_rv = 1'b0;
        chk("err_idle_pulse", err, 1'b1);
        repeat (5) @(negedge clk);
        chk("err_sticky", err, 1'b1);
        chk("busy_after_pulse", busy, 1'b0);
        chk("store_re00", dut.u_store.re_q[0][0], BN'(0));
        chk("store_re10", dut.u_store.re_q[1][0], BN'(4));
        chk("store_im10", dut.u_store.im_q[1][0], -BN'(4));
        rst_n = 1'b0;
        #1 chk("err_cleared", err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset after four jobs have issued
        send_frame(1'b0);
        jobs = 0;
        for (int cyc = 0; cyc < 50 && jobs < 4; cyc++) begin
            if (pe_valid) jobs++;
            @(negedge clk);
        end
        chk("jobs_before_reset", jobs, 4);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_pe_valid", pe_valid, 1'b0);
        chk("midrst_out_valid", out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("err_late_results", err, 1'b1);
        chk("idle_after_late", busy, 1'b0);
        send_frame(1'b0);
        watch_comp();
        recv_frame(-1, 0);

        // 6x3 instance: ingest 18 samples, 9 jobs, full drain
        for (int k = 0; k < 18; k++) begin
            in_valid6 = 1'b1;
            in_re6    = BN'(k);
            in_im6    = -BN'(k);
            @(negedge clk);
        end
        in_valid6 = 1'b0;
        jobs = 0;
        pat  = '0;
        for (int cyc = 0; cyc < 100 && !out_valid6; cyc++) begin
            if (pe_valid6) begin
                pat = {pat[14:0], pe_vec6};
                jobs++;
            end
            @(negedge clk);
        end
        chk("r6_send_reached", out_valid6, 1'b1);
        chk("r6_job_count", jobs, 9);
        chk("r6_vec_pattern", pat, 16'h0124);
        for (int s = 0; s < 18; s++) begin
            ev  = exp_at(s, 6, 3);
            eim = -ev;
            chk("r6_out_re", out_re6, ev);
            chk("r6_out_im", out_im6, eim);
            @(negedge clk);
        end
        chk("r6_out_valid_after", out_valid6, 1'b0);
        chk("r6_busy_after", busy6, 1'b0);
        chk("r6_err", err6, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
